// File: rtl/daa_stream_bridge_if.sv
// Bus bundle for daa_stream_bridge: input word stream, result word stream and the
// wide operand/result side towards the double_and_add_always core.
interface daa_stream_bridge_if;
    // upstream word stream
    logic [1:0]   i_mode;
    logic         i_valid;
    logic [31:0]  i_data;
    logic         o_ready;
    // core side
    logic [1:0]   daa_mode;
    logic         daa_valid;
    logic [255:0] o_daa_pointx;
    logic [255:0] o_daa_pointy;
    logic [255:0] o_daa_prime;
    logic [255:0] o_daa_a;
    logic [255:0] o_daa_b;
    logic [255:0] o_daa_mul;
    logic         daa_finished;
    logic [255:0] daa_outputx;
    logic [255:0] daa_outputy;
    // downstream word stream
    logic         o_valid;
    logic [31:0]  o_data;
    logic         i_ready;
    logic [15:0]  o_run_cycles;

    modport slave (
        input  i_mode, i_valid, i_data, daa_finished, daa_outputx, daa_outputy, i_ready,
        output o_ready, daa_mode, daa_valid, o_daa_pointx, o_daa_pointy, o_daa_prime,
               o_daa_a, o_daa_b, o_daa_mul, o_valid, o_data, o_run_cycles
    );

    modport master (
        output i_mode, i_valid, i_data, daa_finished, daa_outputx, daa_outputy, i_ready,
        input  o_ready, daa_mode, daa_valid, o_daa_pointx, o_daa_pointy, o_daa_prime,
               o_daa_a, o_daa_b, o_daa_mul, o_valid, o_data, o_run_cycles
    );
endinterface

// File: rtl/daa_stream_bridge.sv
// Narrow-bus wrapper for the scalar-multiplication core: gathers 48 input words into six
// 256-bit operands, runs the core until it finishes, then streams the 512-bit result out.
module daa_stream_bridge #(
    parameter int WORD_W    = 32,
    parameter int N_OPWORDS = 8
) (
    input logic           clk,
    input logic           rst,
    daa_stream_bridge_if.slave bus
);
    localparam int N_OPS = 6;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] UNLOAD = 2'd3;

    localparam logic [5:0]  K_LAST  = 6'd47;
    localparam logic [3:0]  J_LAST  = 4'd15;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0] state;
    logic [5:0] k;
    logic [3:0] j;
    logic [1:0] mode_q;
    logic [15:0] run_cycles;

    logic [N_OPS-1:0][N_OPWORDS-1:0][WORD_W-1:0] opnd;
    logic [2*N_OPWORDS-1:0][WORD_W-1:0]          res;

    logic in_acc;
    logic out_acc;

    assign in_acc  = bus.i_valid && bus.o_ready;
    assign out_acc = bus.o_valid && bus.i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            j          <= '0;
            mode_q     <= '0;
            run_cycles <= '0;
            opnd       <= '0;
            res        <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_acc) begin
                        // k[5:3] selects the operand, k[2:0] the word within it
                        opnd[k[5:3]][k[2:0]] <= bus.i_data;
                        if (state == IDLE) begin
                            mode_q     <= bus.i_mode;
                            run_cycles <= '0;
                        end
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= RUN;
                        end else begin
                            k     <= k + 6'd1;
                            state <= LOAD;
                        end
                    end
                end
                RUN: begin
                    if (run_cycles != CNT_MAX)
                        run_cycles <= run_cycles + 16'd1;
                    if (bus.daa_finished) begin
                        res   <= {bus.daa_outputy, bus.daa_outputx};
                        state <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (out_acc) begin
                        if (j == J_LAST) begin
                            j     <= '0;
                            state <= IDLE;
                        end else begin
                            j <= j + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // handshake outputs come from the state register alone
    assign bus.o_ready   = (state == IDLE) || (state == LOAD);
    assign bus.daa_valid = (state == RUN);
    assign bus.o_valid   = (state == UNLOAD);
    assign bus.o_data    = (state == UNLOAD) ? res[j] : '0;

    assign bus.daa_mode     = mode_q;
    assign bus.o_run_cycles = run_cycles;
    assign bus.o_daa_pointx = opnd[0];
    assign bus.o_daa_pointy = opnd[1];
    assign bus.o_daa_prime  = opnd[2];
    assign bus.o_daa_a      = opnd[3];
    assign bus.o_daa_b      = opnd[4];
    assign bus.o_daa_mul    = opnd[5];
endmodule

// File: tb/tb_daa_stream_bridge.sv
// Bench for daa_stream_bridge: directed job table, randomized jobs against a word-level
// model, plus reset-mid-run, spurious-finish and run-counter saturation sequences.
module tb_daa_stream_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    daa_stream_bridge_if bus();
    daa_stream_bridge dut (.clk(clk), .rst(rst), .bus(bus));

    // core stub: finishes combinationally on its stub_target-th valid cycle (0 = never)
    int           stub_cnt;
    int           stub_target;
    logic         spur;
    logic [255:0] rx, ry;

    always @(posedge clk or posedge rst) begin
        if (rst)                 stub_cnt <= 0;
        else if (!bus.daa_valid) stub_cnt <= 0;
        else                     stub_cnt <= stub_cnt + 1;
    end
    assign bus.daa_finished = spur | (bus.daa_valid && (stub_cnt == stub_target - 1));
    assign bus.daa_outputx  = spur ? {8{32'hDEADBEEF}} : rx;
    assign bus.daa_outputy  = spur ? {8{32'hBAADF00D}} : ry;

    int tests = 0;
    int fails = 0;
    logic [31:0] words [48];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] model_op(input int n);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = words[n*8 + w];
        return r;
    endfunction

    function automatic logic [31:0] model_out(input int jj);
        logic [511:0] r;
        r = {ry, rx};
        return r[32*jj +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ops(input logic [1:0] mode);
        chk("pointx", bus.o_daa_pointx, model_op(0));
        chk("pointy", bus.o_daa_pointy, model_op(1));
        chk("prime",  bus.o_daa_prime,  model_op(2));
        chk("a",      bus.o_daa_a,      model_op(3));
        chk("b",      bus.o_daa_b,      model_op(4));
        chk("mul",    bus.o_daa_mul,    model_op(5));
        chk("daa_mode", bus.daa_mode, mode);
    endtask

    task automatic load_job(input logic [1:0] mode, input bit toggle, input int spur_k);
        int k = 0;
        int cyc = 0;
        bit acc;
        while (k < 48 && cyc < 2000) begin
            bus.i_mode  = mode;
            bus.i_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.i_data  = words[k];
            spur        = (spur_k >= 0) && (k == spur_k);
            acc         = bus.i_valid && bus.o_ready;
            tick();
            cyc++;
            if (acc) k++;
        end
        spur        = 1'b0;
        bus.i_valid = 1'b0;
        chk("load_words", k, 48);
        chk("run_entry_daa_valid", bus.daa_valid, 1);
        chk("run_entry_o_ready", bus.o_ready, 0);
    endtask

    task automatic run_unload(input logic [1:0] mode, input bit bp, input int spur_j, input int exp_run);
        int n = 0;
        int jj = 0;
        int stall = 0;
        int cyc = 0;
        bit acc;
        while (!bus.o_valid && n < exp_run + 20) begin
            tick();
            n++;
        end
        chk("run_len", n, exp_run);
        chk("unload_daa_valid", bus.daa_valid, 0);
        chk("run_cycles", bus.o_run_cycles, exp_run);
        chk_ops(mode);
        while (jj < 16 && cyc < 300) begin
            chk($sformatf("o_valid[%0d]", jj), bus.o_valid, 1);
            chk($sformatf("o_data[%0d]", jj), bus.o_data, model_out(jj));
            if (bp && (jj == 0 || jj == 9) && stall < 3) begin
                bus.i_ready = 1'b0;
                stall++;
            end else begin
                bus.i_ready = 1'b1;
            end
            spur = (jj == spur_j);
            acc  = bus.i_ready && bus.o_valid;
            tick();
            cyc++;
            if (acc) begin
                jj++;
                stall = 0;
            end
        end
        bus.i_ready = 1'b0;
        spur        = 1'b0;
        chk("handshakes", jj, 16);
        chk("idle_o_ready", bus.o_ready, 1);
        chk("idle_o_valid", bus.o_valid, 0);
        chk("idle_run_cycles_hold", bus.o_run_cycles, exp_run);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_o_ready"}, bus.o_ready, 1);
        chk({tag, "_daa_valid"}, bus.daa_valid, 0);
        chk({tag, "_o_valid"}, bus.o_valid, 0);
        chk({tag, "_o_data"}, bus.o_data, 0);
        chk({tag, "_daa_mode"}, bus.daa_mode, 0);
        chk({tag, "_run_cycles"}, bus.o_run_cycles, 0);
        chk({tag, "_pointx"}, bus.o_daa_pointx, 0);
        chk({tag, "_mul"}, bus.o_daa_mul, 0);
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic [31:0]  base;
        logic [255:0] x;
        logic [255:0] y;
        bit           toggle;
        bit           bp;
        int           spur_k;
        int           spur_j;
        int           exp_run;
    } vec_t;

    vec_t tbl [3];

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        bit dv_ok;
        tbl[0] = '{2'b01, 32'h1000_0000, 256'hDFA978E7, 256'hF6A1A9BB, 1'b0, 1'b0, -1, -1, 33};
        tbl[1] = '{2'b10, 32'hA000_0000, 256'h1234_5678, 256'hCAFE_0001, 1'b1, 1'b1, -1, -1, 5};
        tbl[2] = '{2'b11, 32'h2000_0000, 256'h888F3531, 256'h71917832, 1'b0, 1'b1, 20, 4, 33};

        rst = 1'b1;
        bus.i_mode = '0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;
        spur = 1'b0; stub_target = 0; rx = '0; ry = '0;
        repeat (3) tick();
        chk_reset_state("reset");
        rst = 1'b0;
        tick();

        // finish strobe in IDLE must not start anything
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_idle_o_ready", bus.o_ready, 1);
        chk("spur_idle_o_valid", bus.o_valid, 0);
        chk("spur_idle_daa_valid", bus.daa_valid, 0);

        foreach (tbl[t]) begin
            for (int k = 0; k < 48; k++) words[k] = tbl[t].base + k;
            rx = tbl[t].x;
            ry = tbl[t].y;
            stub_target = tbl[t].exp_run;
            load_job(tbl[t].mode, tbl[t].toggle, tbl[t].spur_k);
            run_unload(tbl[t].mode, tbl[t].bp, tbl[t].spur_j, tbl[t].exp_run);
        end

        // reset 10 cycles into RUN, then a clean job
        for (int k = 0; k < 48; k++) words[k] = $urandom;
        stub_target = 1000;
        load_job(2'b10, 1'b0, -1);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk_reset_state("rst_run");
        tick();
        rst = 1'b0;
        tick();
        chk_reset_state("rst_after");
        for (int k = 0; k < 48; k++) words[k] = $urandom;
        rx = rnd256();
        ry = rnd256();
        stub_target = 7;
        load_job(2'b01, 1'b0, -1);
        run_unload(2'b01, 1'b0, -1, 7);

        // randomized jobs
        for (int r = 0; r < 6; r++) begin
            logic [1:0] m;
            int fin;
            m = 2'($urandom_range(0, 3));
            fin = $urandom_range(1, 60);
            for (int k = 0; k < 48; k++) words[k] = $urandom;
            rx = rnd256();
            ry = rnd256();
            stub_target = fin;
            load_job(m, 1'($urandom_range(0, 1)), -1);
            run_unload(m, 1'($urandom_range(0, 1)), -1, fin);
        end

        // run counter saturation with a core that never finishes
        for (int k = 0; k < 48; k++) words[k] = $urandom;
        stub_target = 0;
        load_job(2'b00, 1'b0, -1);
        dv_ok = 1'b1;
        for (int n = 1; n <= 70000; n++) begin
            tick();
            if (!bus.daa_valid) dv_ok = 1'b0;
            if (n == 1000)  chk("run_cycles_1000", bus.o_run_cycles, 1000);
            if (n == 65535) chk("run_cycles_65535", bus.o_run_cycles, 16'hFFFF);
        end
        chk("sat_daa_valid_held", dv_ok, 1);
        chk("sat_run_cycles", bus.o_run_cycles, 16'hFFFF);
        chk("sat_o_valid", bus.o_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/daa_stream_bridge.md
# daa_stream_bridge

Upstream/downstream wrapper for the `double_and_add_always` scalar-multiplication core. It accepts the six 256-bit operands as a 32-bit word stream over a valid/ready handshake. It then holds `daa_valid` high until the core reports `o_daa_finished` and captures the result point. Finally it streams the result back as 32-bit words over a second valid/ready handshake, so the wide core can sit behind a narrow bus.

## Interface
- WORD_W, 32, stream word width; the only supported value.
- N_OPWORDS, 8, words per 256-bit operand.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_mode  input  2  mode; sampled on the first accepted input word.
- i_valid  input  1  input word valid.
- i_data  input  32  input word.
- o_ready  output  1  bridge can accept a word.
- daa_mode  output  2  registered mode to the core.
- daa_valid  output  1  run request to the core.
- o_daa_pointx, o_daa_pointy, o_daa_prime, o_daa_a, o_daa_b, o_daa_mul  output  256 each  operand registers to the core.
- daa_finished  input  1  core done; may assert combinationally in a cycle where `daa_valid=1`.
- daa_outputx, daa_outputy  input  256 each  result, valid only while `daa_finished=1`.
- o_valid  output  1  result word valid.
- o_data  output  32  result word.
- i_ready  input  1  consumer accepts the word.
- o_run_cycles  output  16  count of RUN cycles for the last job; saturates at 16'hFFFF.

## Operation
- **States:** IDLE, LOAD, RUN, UNLOAD. Encoding is free.
- **IDLE:**
  - `o_ready=1`.
  - On accept (`i_valid & o_ready`): store word 0, latch `i_mode` into `daa_mode`, clear `o_run_cycles`, go to LOAD.
- **LOAD:**
  - `o_ready=1`. Input word index `k` runs 0..47.
  - Operand order: 0=pointx, 1=pointy, 2=prime, 3=a, 4=b, 5=mul.
  - Operand number is `k/8`; word `w = k%8` is written to bits `[32w+31:32w]`. Words arrive least-significant first.
  - Accepting word 47 moves the FSM to RUN.
  - `i_valid=0` cycles stall with no state change.
- **RUN:**
  - `daa_valid=1`, `o_ready=0`. `o_run_cycles` increments each cycle, saturating.
  - In a cycle with `daa_finished=1`: capture `daa_outputx`/`daa_outputy` into a 512-bit result register and go to UNLOAD.
  - `daa_finished` is ignored in every state except RUN.
- **UNLOAD:**
  - `o_valid=1`. Output word index `j` runs 0..15.
  - `o_data` is result x word `j` for `j<8`, and y word `j-8` for `j>=8`, least-significant first.
  - `j` advances on `o_valid & i_ready`. Accepting word 15 returns the FSM to IDLE.
- **Registers across jobs:** operand registers and `daa_mode` hold their values until overwritten by the next job. `o_run_cycles` holds until the next job's first word.
- **Counters:** `k` is 6 bits and `j` is 4 bits; both reset to 0 on entering IDLE. There is no wrap within a job.
- **Reset:** asserting `rst` in any state, including mid-LOAD, RUN or UNLOAD, immediately forces:
  - state IDLE;
  - all operand, result and mode registers to 0;
  - `k=j=0`, `o_run_cycles=0`;
  - `daa_valid=0`, `o_valid=0`, `o_ready=1` after reset.
  
  A partial job is discarded. The core is reset by the same `rst`.

## Timing
- **Reset values:** `o_ready=1`, `daa_valid=0`, `o_valid=0`, `o_data=0`, `daa_mode=0`, all 256-bit outputs 0, `o_run_cycles=0`.
- **Output sources:** `o_ready`, `daa_valid` and `o_valid` are decoded from the state register only; none has a combinational path from any input.
- **Load:** minimum 48 cycles. The last word is accepted at edge E; `daa_valid` is high from the cycle after E.
- **Run:**
  - With the finish at edge F, `daa_valid` is 0 and `o_valid` is 1 in the cycle after F.
  - `o_run_cycles` counts the cycles in RUN, including the finishing cycle.
- **Unload:** minimum 16 cycles. `o_data` is stable while `o_valid & !i_ready` (hold requirement).
- **Job rate:** the next job's first word can be accepted in the cycle after the 16th output handshake.
- **Throughput bound:** 48 + run + 16 cycles per job, with no overlap between jobs.

## Test plan
- **Basic job:**
  - Stimulus: `i_mode=2'b01`, words `k=0..47` with value `32'h1000_0000+k`, back-to-back. Core stub finishes on its 33rd valid cycle, returning x=`256'hDFA978E7`, y=`256'hF6A1A9BB`.
  - Required: `o_daa_pointx[31:0]=32'h1000_0000`, `o_daa_mul[255:224]=32'h1000_002F`, `daa_mode=1`, `o_run_cycles=33`.
  - Required output sequence: `DFA978E7`, then 7×0, then `F6A1A9BB`, then 7×0.
- **Back-pressure:**
  - Stimulus: `i_valid` toggling 1/0 during load; `i_ready` low for 3 cycles at `j=0` and `j=9`.
  - Required: no word lost or duplicated, `o_data` held during stalls, 16 handshakes total.
- **Second job:** with the same stub, run a second job; the stub returns x=`256'h888F3531`, y=`256'h71917832`. Required: the new result is streamed and `o_run_cycles=33`.
- **Spurious finish:** `daa_finished=1` pulsed in IDLE, LOAD and UNLOAD. Required: no state change and no result capture.
- **Reset mid-RUN:** assert `rst` 10 cycles into RUN. Required: `daa_valid=0` immediately, all operand outputs 0, `o_ready=1`; a following full job completes correctly.
- **Saturation:** stub never finishes for 70000 cycles. Required: `o_run_cycles` stays at `16'hFFFF` and `daa_valid` stays 1.
